// File: rtl/qif_synapse_current.sv
// Synaptic current front end for the QIF neuron.
// Spike events look up a programmable signed weight and add it to the
// signed 8-bit current with saturation; between events the current decays
// exponentially toward zero on a prescaled tick.
module qif_synapse_current #(
    parameter int N_SYN        = 4,
    parameter int DECAY_SHIFT  = 3,
    parameter int DECAY_PERIOD = 4,
    localparam int AW          = $clog2(N_SYN),
    localparam int CW          = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spike_valid,
    output logic                spike_ready,
    input  logic [AW-1:0]       spike_addr,
    input  logic                wt_we,
    input  logic [AW-1:0]       wt_addr,
    input  logic signed [7:0]   wt_data,
    output logic signed [7:0]   I_syn,
    output logic [7:0]          event_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ACCUM  = 2'd2
    } state_t;

    // Clamp a 9-bit signed sum into the 8-bit signed current range.
    function automatic logic signed [7:0] sat8(input logic signed [8:0] v);
        logic signed [7:0] r;
        if (v > 9'sd127) begin
            r = 8'sd127;
        end else if (v < -9'sd128) begin
            r = -8'sd128;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    // One exponential decay step; small positive values are forced down by
    // at least one so they cannot stall above zero.
    function automatic logic signed [7:0] decay8(input logic signed [7:0] v);
        logic signed [7:0] d;
        d = v >>> DECAY_SHIFT;
        if ((d == 8'sd0) && (v > 8'sd0)) begin
            d = 8'sd1;
        end else begin
            d = d;
        end
        return v - d;
    endfunction

    state_t                 state_r;
    logic [AW-1:0]          addr_r;
    logic signed [7:0]      w_r;
    logic signed [7:0]      weights_r [N_SYN];
    logic                   spike_ready_r;
    logic signed [7:0]      i_syn_r;
    logic [7:0]             event_count_r;
    logic [CW-1:0]          cnt_r;
    logic                   tick_s;
    logic signed [7:0]      i_base_s;
    logic signed [7:0]      i_next_s;

    assign tick_s      = (cnt_r == CW'(DECAY_PERIOD - 1));
    assign spike_ready = spike_ready_r;
    assign I_syn       = i_syn_r;
    assign event_count = event_count_r;

    // Free-running decay prescaler, wraps after the tick cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Weight register file, writable at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SYN; i++) begin
                weights_r[i] <= 8'sd0;
            end
        end else if (wt_we) begin
            weights_r[wt_addr] <= wt_data;
        end else begin
            weights_r[wt_addr] <= weights_r[wt_addr];
        end
    end

    // Next current: decay first on a tick, then add the weight in ACCUM.
    always_comb begin
        i_base_s = i_syn_r;
        i_next_s = i_syn_r;
        if (tick_s) begin
            i_base_s = decay8(i_syn_r);
        end else begin
            i_base_s = i_syn_r;
        end
        if (state_r == ST_ACCUM) begin
            i_next_s = sat8({i_base_s[7], i_base_s} + {w_r[7], w_r});
        end else begin
            i_next_s = i_base_s;
        end
    end

    // Event FSM with registered ready, current and event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            addr_r        <= {AW{1'b0}};
            w_r           <= 8'sd0;
            spike_ready_r <= 1'b1;
            i_syn_r       <= 8'sd0;
            event_count_r <= 8'd0;
        end else begin
            i_syn_r <= i_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (spike_valid && spike_ready_r) begin
                        addr_r        <= spike_addr;
                        state_r       <= ST_LOOKUP;
                        spike_ready_r <= 1'b0;
                        if (event_count_r != 8'd255) begin
                            event_count_r <= event_count_r + 8'd1;
                        end else begin
                            event_count_r <= event_count_r;
                        end
                    end else begin
                        state_r       <= ST_IDLE;
                        spike_ready_r <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    // Reads the pre-write value if the same entry is written now.
                    w_r     <= weights_r[addr_r];
                    state_r <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    state_r       <= ST_IDLE;
                    spike_ready_r <= 1'b1;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    spike_ready_r <= 1'b1;
                end
            endcase
        end
    end

endmodule
